// File: rtl/dma_irq_pkg.sv
// rtl/dma_irq_pkg.sv - shared constants and state encoding for the DMA interrupt coalescer
package dma_irq_pkg;

   localparam int IRQ_RIP = 0;
   localparam int IRQ_WIP = 1;
   localparam int IRQ_CIP = 2;
   localparam int NumIrq  = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      FIRE  = 2'd2
   } coal_state_e;

endpackage

// File: rtl/dma_irq_timeout_timer.sv
// rtl/dma_irq_timeout_timer.sv - loadable down-counter, expiry pulse on the decrement that reaches 0
module dma_irq_timeout_timer #(
   parameter int Width = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic [Width-1:0] load_val_i,
   input  logic             run_i,
   output logic             expired_o
);

   logic [Width-1:0] count;

   // A loaded value of 0 never expires: the counter parks at 0.
   assign expired_o = run_i && !load_i && (count == Width'(1));

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count <= '0;
      end else if (load_i) begin
         count <= load_val_i;
      end else if (run_i && (count != '0)) begin
         count <= count - Width'(1);
      end
   end

endmodule

// File: rtl/dma_irq_coalescer.sv
// rtl/dma_irq_coalescer.sv - sticky W1C DMA pending bits with coalesced completion interrupt
// DMA_IRQ_TIMEOUT_EN builds in the coalescing timeout; otherwise cip fires on threshold only.
module dma_irq_coalescer
   import dma_irq_pkg::*;
#(
   parameter int CntWidth     = 16,
   parameter int TimeoutWidth = 16
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    r_done_i,
   input  logic                    w_done_i,
   input  logic                    xfer_done_i,
   input  logic [NumIrq-1:0]       irq_en_i,
   input  logic [NumIrq-1:0]       clr_i,
   input  logic [CntWidth-1:0]     cfg_threshold_i,
   input  logic [TimeoutWidth-1:0] cfg_timeout_i,
   output logic [NumIrq-1:0]       pending_o,
   output logic [NumIrq-1:0]       irq_o,
   output logic [CntWidth-1:0]     done_cnt_o,
   output logic [CntWidth-1:0]     coal_cnt_o
);

   coal_state_e         state;
   logic [CntWidth-1:0] thr;
   logic [CntWidth-1:0] coal_inc;
   logic [CntWidth-1:0] coal_next;
   logic                timer_load;
   logic                timer_expired;

   assign thr        = (cfg_threshold_i == '0) ? CntWidth'(1) : cfg_threshold_i;
   assign coal_inc   = (coal_cnt_o == '1) ? coal_cnt_o : coal_cnt_o + CntWidth'(1);
   assign coal_next  = xfer_done_i ? coal_inc : coal_cnt_o;
   assign timer_load = xfer_done_i && ((state == IDLE) || (state == FIRE));
   assign irq_o      = pending_o & irq_en_i;

`ifdef DMA_IRQ_TIMEOUT_EN
   logic timer_pulse;

   dma_irq_timeout_timer #(
      .Width (TimeoutWidth)
   ) u_timer (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .load_i     (timer_load),
      .load_val_i (cfg_timeout_i),
      .run_i      (state == ACCUM),
      .expired_o  (timer_pulse)
   );

   assign timer_expired = timer_pulse && (cfg_timeout_i != '0);
`else
   logic unused_timeout;
   assign unused_timeout = (^cfg_timeout_i) ^ timer_load;
   assign timer_expired  = 1'b0;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state      <= IDLE;
         coal_cnt_o <= '0;
         pending_o  <= '0;
         done_cnt_o <= '0;
      end else begin
         done_cnt_o         <= done_cnt_o + CntWidth'(xfer_done_i);
         // Set has priority over a simultaneous W1C clear on every bit.
         pending_o[IRQ_RIP] <= r_done_i || (pending_o[IRQ_RIP] && !clr_i[IRQ_RIP]);
         pending_o[IRQ_WIP] <= w_done_i || (pending_o[IRQ_WIP] && !clr_i[IRQ_WIP]);
         pending_o[IRQ_CIP] <= (state == FIRE) || (pending_o[IRQ_CIP] && !clr_i[IRQ_CIP]);

         case (state)
            IDLE: begin
               if (xfer_done_i) begin
                  coal_cnt_o <= CntWidth'(1);
                  state      <= (thr == CntWidth'(1)) ? FIRE : ACCUM;
               end
            end
            ACCUM: begin
               coal_cnt_o <= coal_next;
               // ">=" also catches a threshold lowered below the running count.
               if ((coal_next >= thr) || timer_expired) begin
                  state <= FIRE;
               end
            end
            FIRE: begin
               if (xfer_done_i) begin
                  coal_cnt_o <= CntWidth'(1);
                  state      <= (thr == CntWidth'(1)) ? FIRE : ACCUM;
               end else begin
                  coal_cnt_o <= '0;
                  state      <= IDLE;
               end
            end
            default: begin
               coal_cnt_o <= '0;
               state      <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dma_irq_coalescer.sv
// tb/tb_dma_irq_coalescer.sv - directed self-checking bench for dma_irq_coalescer
module tb_dma_irq_coalescer;

   logic        clk = 1'b0;
   logic        rst;
   logic        r_done;
   logic        w_done;
   logic        xfer_done;
   logic [2:0]  irq_en;
   logic [2:0]  clr;
   logic [15:0] cfg_threshold;
   logic [15:0] cfg_timeout;
   logic [2:0]  pending;
   logic [2:0]  irq;
   logic [15:0] done_cnt;
   logic [15:0] coal_cnt;

   int errors = 0;
   int checks = 0;

   dma_irq_coalescer #(
      .CntWidth     (16),
      .TimeoutWidth (16)
   ) dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .r_done_i        (r_done),
      .w_done_i        (w_done),
      .xfer_done_i     (xfer_done),
      .irq_en_i        (irq_en),
      .clr_i           (clr),
      .cfg_threshold_i (cfg_threshold),
      .cfg_timeout_i   (cfg_timeout),
      .pending_o       (pending),
      .irq_o           (irq),
      .done_cnt_o      (done_cnt),
      .coal_cnt_o      (coal_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; r_done = 1'b0; w_done = 1'b0; xfer_done = 1'b0;
      irq_en = 3'b000; clr = 3'b000; cfg_threshold = 16'd1; cfg_timeout = 16'd0;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (pending !== 3'b000) begin errors++; $display("FAIL reset_pending got=%b exp=000", pending); end
      checks++; if (irq !== 3'b000) begin errors++; $display("FAIL reset_irq got=%b exp=000", irq); end
      checks++; if (done_cnt !== 16'd0) begin errors++; $display("FAIL reset_done_cnt got=%0d exp=0", done_cnt); end
      checks++; if (coal_cnt !== 16'd0) begin errors++; $display("FAIL reset_coal_cnt got=%0d exp=0", coal_cnt); end
   endtask

   task automatic test_rip();
      do_reset();
      irq_en = 3'b001;
      r_done = 1'b1; tick(); r_done = 1'b0;
      checks++; if (pending !== 3'b001) begin errors++; $display("FAIL rip_set got=%b exp=001", pending); end
      checks++; if (irq !== 3'b001) begin errors++; $display("FAIL rip_irq got=%b exp=001", irq); end
      clr = 3'b001; tick(); clr = 3'b000;
      checks++; if (pending !== 3'b000) begin errors++; $display("FAIL rip_clr got=%b exp=000", pending); end
      checks++; if (irq !== 3'b000) begin errors++; $display("FAIL rip_clr_irq got=%b exp=000", irq); end
   endtask

   task automatic test_wip_set_wins();
      do_reset();
      irq_en = 3'b001;
      w_done = 1'b1; clr = 3'b010; tick(); w_done = 1'b0; clr = 3'b000;
      checks++; if (pending !== 3'b010) begin errors++; $display("FAIL wip_set_wins got=%b exp=010", pending); end
      checks++; if (irq !== 3'b000) begin errors++; $display("FAIL wip_masked got=%b exp=000", irq); end
      irq_en = 3'b010; #1;
      checks++; if (irq !== 3'b010) begin errors++; $display("FAIL wip_enabled got=%b exp=010", irq); end
      clr = 3'b010; tick(); clr = 3'b000;
      checks++; if (pending !== 3'b000) begin errors++; $display("FAIL wip_clr got=%b exp=000", pending); end
   endtask

   task automatic test_threshold();
      do_reset();
      cfg_threshold = 16'd4; cfg_timeout = 16'd0; irq_en = 3'b100;
      xfer_done = 1'b1; repeat (4) tick(); xfer_done = 1'b0;
      checks++; if (pending[2] !== 1'b0) begin errors++; $display("FAIL thr_cip_early got=%b exp=0", pending[2]); end
      checks++; if (coal_cnt !== 16'd4) begin errors++; $display("FAIL thr_coal_fire got=%0d exp=4", coal_cnt); end
      tick();
      checks++; if (pending !== 3'b100) begin errors++; $display("FAIL thr_cip got=%b exp=100", pending); end
      checks++; if (irq !== 3'b100) begin errors++; $display("FAIL thr_irq got=%b exp=100", irq); end
      checks++; if (coal_cnt !== 16'd0) begin errors++; $display("FAIL thr_coal_clr got=%0d exp=0", coal_cnt); end
      checks++; if (done_cnt !== 16'd4) begin errors++; $display("FAIL thr_done_cnt got=%0d exp=4", done_cnt); end
      clr = 3'b100; tick(); clr = 3'b000;
      checks++; if (pending[2] !== 1'b0) begin errors++; $display("FAIL thr_cip_clr got=%b exp=0", pending[2]); end
   endtask

   task automatic test_lowered_threshold();
      do_reset();
      cfg_threshold = 16'd8; cfg_timeout = 16'd0;
      xfer_done = 1'b1; repeat (3) tick(); xfer_done = 1'b0;
      checks++; if (coal_cnt !== 16'd3) begin errors++; $display("FAIL low_coal got=%0d exp=3", coal_cnt); end
      cfg_threshold = 16'd2;
      tick();
      checks++; if (pending[2] !== 1'b0) begin errors++; $display("FAIL low_cip_early got=%b exp=0", pending[2]); end
      tick();
      checks++; if (pending[2] !== 1'b1) begin errors++; $display("FAIL low_cip got=%b exp=1", pending[2]); end
   endtask

   task automatic test_timeout();
      do_reset();
      cfg_threshold = 16'd8; cfg_timeout = 16'd10;
      xfer_done = 1'b1; repeat (3) tick(); xfer_done = 1'b0;
      repeat (8) tick();
      checks++; if (pending[2] !== 1'b0) begin errors++; $display("FAIL tmo_cip_early got=%b exp=0", pending[2]); end
      tick();
`ifdef DMA_IRQ_TIMEOUT_EN
      checks++; if (pending[2] !== 1'b1) begin errors++; $display("FAIL tmo_cip got=%b exp=1", pending[2]); end
      checks++; if (coal_cnt !== 16'd0) begin errors++; $display("FAIL tmo_coal got=%0d exp=0", coal_cnt); end
`else
      repeat (20) tick();
      checks++; if (pending[2] !== 1'b0) begin errors++; $display("FAIL tmo_off_cip got=%b exp=0", pending[2]); end
      checks++; if (coal_cnt !== 16'd3) begin errors++; $display("FAIL tmo_off_coal got=%0d exp=3", coal_cnt); end
`endif
      checks++; if (done_cnt !== 16'd3) begin errors++; $display("FAIL tmo_done_cnt got=%0d exp=3", done_cnt); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      cfg_threshold = 16'd1; cfg_timeout = 16'd0;
      xfer_done = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (coal_cnt !== 16'd1) begin errors++; $display("FAIL b2b_coal[%0d] got=%0d exp=1", i, coal_cnt); end
      end
      xfer_done = 1'b0;
      checks++; if (pending[2] !== 1'b1) begin errors++; $display("FAIL b2b_cip got=%b exp=1", pending[2]); end
      checks++; if (done_cnt !== 16'd5) begin errors++; $display("FAIL b2b_done_cnt got=%0d exp=5", done_cnt); end
      tick();
      checks++; if (coal_cnt !== 16'd0) begin errors++; $display("FAIL b2b_coal_idle got=%0d exp=0", coal_cnt); end
   endtask

   task automatic test_wrap();
      do_reset();
      cfg_threshold = 16'd0; cfg_timeout = 16'd0;
      xfer_done = 1'b1;
      repeat (65535) tick();
      checks++; if (done_cnt !== 16'hFFFF) begin errors++; $display("FAIL wrap_preset got=%0h exp=ffff", done_cnt); end
      checks++; if (coal_cnt !== 16'd1) begin errors++; $display("FAIL thr0_coal got=%0d exp=1", coal_cnt); end
      tick();
      xfer_done = 1'b0;
      checks++; if (done_cnt !== 16'd0) begin errors++; $display("FAIL wrap_zero got=%0h exp=0", done_cnt); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      cfg_threshold = 16'd8; irq_en = 3'b111;
      r_done = 1'b1; xfer_done = 1'b1; repeat (2) tick(); r_done = 1'b0; xfer_done = 1'b0;
      checks++; if (coal_cnt !== 16'd2) begin errors++; $display("FAIL mid_coal got=%0d exp=2", coal_cnt); end
      checks++; if (pending !== 3'b001) begin errors++; $display("FAIL mid_pending got=%b exp=001", pending); end
      rst = 1'b1; tick(); rst = 1'b0;
      checks++; if (pending !== 3'b000) begin errors++; $display("FAIL mid_rst_pending got=%b exp=000", pending); end
      checks++; if (irq !== 3'b000) begin errors++; $display("FAIL mid_rst_irq got=%b exp=000", irq); end
      checks++; if (done_cnt !== 16'd0) begin errors++; $display("FAIL mid_rst_done got=%0d exp=0", done_cnt); end
      checks++; if (coal_cnt !== 16'd0) begin errors++; $display("FAIL mid_rst_coal got=%0d exp=0", coal_cnt); end
      cfg_threshold = 16'd2;
      xfer_done = 1'b1; tick(); xfer_done = 1'b0;
      checks++; if (coal_cnt !== 16'd1) begin errors++; $display("FAIL mid_restart got=%0d exp=1", coal_cnt); end
   endtask

   initial begin
      test_reset();
      test_rip();
      test_wip_set_wins();
      test_threshold();
      test_lowered_threshold();
      test_timeout();
      test_back_to_back();
      test_wrap();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
